rca_mp_add_seq: RTL and testbench
=================================

// Module: rca_mp_add_seq
// PURPOSE
//   Sequencer that runs NBYTES-wide add/subtract operations through one shared 8-bit
//   ripple-carry adder slice, least significant byte first, one byte per cycle.
//   Carry is chained between bytes.
//   Operands are accepted on a valid/ready input port. The full-width result, carry and
//   signed overflow are returned on a valid/ready output port.
//   The block sits between the operand source and the adder slice. The slice registers
//   A/B/CI on clk; S/CO are combinational from those registers.
// PARAMETERS
//   NBYTES  4  operand width in bytes (>=1); datapath width W = 8*NBYTES
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   in_valid   in   1   operand request
//   in_ready   out  1   block can accept an operation (IDLE only)
//   in_a       in   W   operand A
//   in_b       in   W   operand B
//   in_ci      in   1   carry-in (add mode only)
//   in_sub     in   1   1 = A-B (B inverted, CI forced 1); 0 = A+B+in_ci
//   out_valid  out  1   result available
//   out_ready  in   1   result consumer ready
//   out_sum    out  W   result
//   out_co     out  1   final carry-out (sub: 1 = no borrow)
//   out_ovf    out  1   signed two's-complement overflow
//   busy       out  1   operation in flight (ISSUE or DRAIN)
//   add_a      out  8   byte to adder A
//   add_b      out  8   byte to adder B (already inverted in sub mode)
//   add_ci     out  1   adder carry-in
//   add_s      in   8   adder sum
//   add_co     in   1   adder carry-out
// BEHAVIOUR
//   Reset values:
//     state=IDLE, in_ready=1, out_valid=0, busy=0
//     out_sum=0, out_co=0, out_ovf=0, add_a/add_b/add_ci=0
//   States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready, latch a, b^{W{sub}}, ci0 = sub ? 1 : in_ci; beat=0.
//     - Go to ISSUE.
//   ISSUE (beat k = 0..NBYTES-1, one cycle each):
//     - add_a = A[8k+7:8k], add_b = B'[8k+7:8k].
//     - add_ci = (k==0) ? ci0 : add_co. add_co is taken combinationally here; it
//       carries byte k-1's carry.
//     - If k>=1, capture add_s into sum byte k-1 at the clock edge.
//     - After k=NBYTES-1, go to DRAIN.
//   DRAIN (1 cycle):
//     - add_a/add_b/add_ci = 0.
//     - Capture add_s into byte NBYTES-1 and add_co into out_co.
//     - out_ovf = (A[W-1]==B'[W-1]) && (add_s[7]!=A[W-1]).
//     - Go to DONE.
//   DONE:
//     - out_valid=1.
//     - out_sum/out_co/out_ovf are held stable while out_ready=0.
//     - On out_ready, go to IDLE; out_valid drops the next cycle.
//   Latency: accept edge -> out_valid high after NBYTES+1 cycles (ISSUE*NBYTES + DRAIN).
//   Throughput: 1 operation per NBYTES+3 cycles minimum.
//   Fixed: no accept in DONE, and no same-cycle accept on result handoff.
//   out_sum keeps the last result in IDLE. It is updated only by the capture edges.
//   add_s/add_co are ignored outside ISSUE(k>=1)/DRAIN. The adder flops have no reset,
//   so their values are don't-care until first issue.
//   in_a/in_b/in_sub/in_ci are sampled only at the accept edge. Later changes have no effect.
//   Reset mid-operation: abort immediately. All state and outputs return to reset values.
//   The partial result is discarded and the first operation after reset is correct.
//   NBYTES=1: ISSUE lasts 1 cycle with add_ci=ci0; then DRAIN, then DONE.
//   Width: out_sum = (A + B' + ci0) mod 2^W; out_co = bit W of that sum.
// TESTING
//   1 NBYTES=4, A=FFFFFFFF B=00000001 ci=0 add:
//     out_sum=00000000, co=1, ovf=0; out_valid exactly 5 cycles after accept.
//   2 Sub, A=00000005 B=00000007:
//     out_sum=FFFFFFFE, co=0 (borrow), ovf=0.
//     Check add_ci=1 on beat 0 and add_b=F8 on beat 0.
//   3 A=7FFFFFFF B=00000001 add: out_sum=80000000, ovf=1, co=0.
//     Sub, A=80000000 B=00000001: out_sum=7FFFFFFF, ovf=1, co=1.
//   4 Backpressure: hold out_ready=0 for 3 cycles in DONE.
//     -> out_sum/co/ovf stable, in_ready=0, in_valid ignored.
//     Then out_ready=1 -> IDLE, in_ready=1 next cycle.
//   5 Assert rst_n=0 during ISSUE beat 2 of A=12345678 B=11111111.
//     -> all outputs 0, in_ready=1.
//     Then A=00000001 B=00000002 -> out_sum=00000003.
//   6 NBYTES=1, A=FF B=FF ci=1: out_sum=FF, co=1, ovf=0, latency 2 cycles.
//     Random A/B/sub vs a reference model, 1000 operations.

Source files
------------

// File: rtl/rca_mp_add_seq.sv
// rca_mp_add_seq
//   Runs NBYTES-wide add/subtract operations through one shared external
//   8-bit ripple-carry adder slice, least significant byte first, one byte
//   per cycle, chaining the carry between bytes. The slice registers
//   add_a/add_b/add_ci on clk and returns add_s/add_co combinationally from
//   those registers, so each byte's result comes back one cycle after issue.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready          operand handshake (accepts only in IDLE)
//   in_a, in_b, in_ci, in_sub  operands, carry-in, subtract select
//   out_valid/out_ready        result handshake (valid only in DONE)
//   out_sum, out_co, out_ovf   result, final carry-out, signed overflow
//   busy                       operation in flight (ISSUE or DRAIN)
//   add_a, add_b, add_ci       byte operands to the adder slice
//   add_s, add_co              adder slice sum / carry-out
module rca_mp_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_ci,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_co,
    output logic                  out_ovf,
    output logic                  busy,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_ci,
    input  logic [7:0]            add_s,
    input  logic                  add_co
);

    localparam int W  = 8 * NBYTES;
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;       // B already inverted in subtract mode
    logic            ci0_q, ci0_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            co_q, co_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      a_byte, b_byte;

    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand holding registers: only read during ISSUE/DRAIN, so no reset needed
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        ci0_q <= ci0_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)            state_d = S_ISSUE;
            S_ISSUE: if (beat_q == LAST_BEAT) state_d = S_DRAIN;
            S_DRAIN:                          state_d = S_DONE;
            S_DONE:  if (out_ready)           state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Byte of the current beat
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (beat_q == BW'(k)) begin
                a_byte = a_q[8*k +: 8];
                b_byte = b_q[8*k +: 8];
            end
        end
    end

    // Datapath next-state: operand latch, byte captures, final flags
    always_comb begin
        beat_d = beat_q;
        a_d    = a_q;
        b_d    = b_q;
        ci0_d  = ci0_q;
        sum_d  = sum_q;
        co_d   = co_q;
        ovf_d  = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = in_a;
                    b_d    = in_b ^ {W{in_sub}};
                    ci0_d  = in_sub | in_ci;
                    beat_d = '0;
                end
            end
            S_ISSUE: begin
                // The slice output now holds byte k-1's result
                for (int k = 1; k < NBYTES; k++) begin
                    if (beat_q == BW'(k)) sum_d[8*(k-1) +: 8] = add_s;
                end
                beat_d = beat_q + BW'(1);
            end
            S_DRAIN: begin
                sum_d[W-1 -: 8] = add_s;
                co_d  = add_co;
                // Overflow: like-signed operands producing a result of the other sign
                ovf_d = (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        add_a     = '0;
        add_b     = '0;
        add_ci    = 1'b0;
        if (state_q == S_ISSUE) begin
            add_a  = a_byte;
            add_b  = b_byte;
            // Beyond beat 0 the slice's carry-out is the previous byte's carry
            add_ci = (beat_q == '0) ? ci0_q : add_co;
        end
    end

    assign out_sum = sum_q;
    assign out_co  = co_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_rca_mp_add_seq.sv
module tb_rca_mp_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // NBYTES=4 instance
    logic        iv4, ir4, ci4, sub4, ov4, or4, co4, ovf4, busy4, aci4, aco4;
    logic [31:0] a4, b4, s4;
    logic [7:0]  aa4, ab4, as4, ra4, rb4;
    logic        rc4;

    // NBYTES=1 instance
    logic        iv1, ir1, ci1, sub1, ov1, or1, co1, ovf1, busy1, aci1, aco1;
    logic [7:0]  a1, b1, s1;
    logic [7:0]  aa1, ab1, as1, ra1, rb1;
    logic        rc1;

    int ncmp  = 0;
    int nfail = 0;

    rca_mp_add_seq #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4), .in_ci(ci4), .in_sub(sub4),
        .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_co(co4), .out_ovf(ovf4),
        .busy(busy4), .add_a(aa4), .add_b(ab4), .add_ci(aci4), .add_s(as4), .add_co(aco4)
    );

    rca_mp_add_seq #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1), .in_ci(ci1), .in_sub(sub1),
        .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_co(co1), .out_ovf(ovf1),
        .busy(busy1), .add_a(aa1), .add_b(ab1), .add_ci(aci1), .add_s(as1), .add_co(aco1)
    );

    // Adder slices: registered inputs, combinational sum/carry, no reset
    always_ff @(posedge clk) begin
        ra4 <= aa4; rb4 <= ab4; rc4 <= aci4;
        ra1 <= aa1; rb1 <= ab1; rc1 <= aci1;
    end
    assign {aco4, as4} = {1'b0, ra4} + {1'b0, rb4} + {8'd0, rc4};
    assign {aco1, as1} = {1'b0, ra1} + {1'b0, rb1} + {8'd0, rc1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on nb-byte operands
    function automatic void ref_op(input int nb, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub,
                                   output logic [31:0] s, output logic co, output logic ovf);
        longint m, ua, ub, sa, sb, u, sv;
        m  = longint'(1) << (8 * nb);
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub) begin
            u  = (ua - ub + m) % m;
            co = (ua >= ub);
            sv = sa - sb;
        end else begin
            u  = ua + ub + longint'(ci);
            co = (u >= m);
            u  = u % m;
            sv = sa + sb + longint'(ci);
        end
        s   = u[31:0];
        ovf = (sv > m / 2 - 1) || (sv < -(m / 2));
    endfunction

    // One operation; hold = cycles of out_ready=0 in DONE with a competing in_valid
    task automatic run_op(input bit one, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sub, input int hold,
                          output logic [31:0] s, output logic co, output logic ovf,
                          output int lat, output logic [7:0] b0, output logic c0);
        int n;
        if (one) begin a1 = a[7:0]; b1 = b[7:0]; ci1 = ci; sub1 = sub; iv1 = 1'b1; end
        else     begin a4 = a;      b4 = b;      ci4 = ci; sub4 = sub; iv4 = 1'b1; end
        n = 0;
        while (!(one ? ir1 : ir4) && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        // Accepted: scramble inputs, they must no longer matter
        if (one) begin iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); ci1 = 1'($urandom); sub1 = 1'($urandom); end
        else     begin iv4 = 1'b0; a4 = $urandom; b4 = $urandom; ci4 = 1'($urandom); sub4 = 1'($urandom); end
        b0 = one ? ab1 : ab4;
        c0 = one ? aci1 : aci4;
        lat = 0;
        while (!(one ? ov1 : ov4) && lat < 50) begin @(posedge clk); #1; lat++; end
        s   = one ? {24'd0, s1} : s4;
        co  = one ? co1 : co4;
        ovf = one ? ovf1 : ovf4;
        if (hold > 0) begin
            if (one) iv1 = 1'b1; else iv4 = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("bp_sum",       one ? {24'd0, s1} : s4, s);
                chk("bp_co",        one ? co1 : co4, co);
                chk("bp_ovf",       one ? ovf1 : ovf4, ovf);
                chk("bp_in_ready",  one ? ir1 : ir4, 0);
                chk("bp_out_valid", one ? ov1 : ov4, 1);
            end
            if (one) iv1 = 1'b0; else iv4 = 1'b0;
        end
        if (one) or1 = 1'b1; else or4 = 1'b1;
        @(posedge clk); #1;
        if (one) or1 = 1'b0; else or4 = 1'b0;
        chk("post_in_ready",  one ? ir1 : ir4, 1);
        chk("post_out_valid", one ? ov1 : ov4, 0);
    endtask

    initial begin
        logic [31:0] s, es, ra, rb;
        logic        co, ovf, eco, eovf, c0, rci, rsub;
        logic [7:0]  b0;
        int          lat;

        rst_n = 1'b0;
        iv4 = 0; a4 = '0; b4 = '0; ci4 = 0; sub4 = 0; or4 = 0;
        iv1 = 0; a1 = '0; b1 = '0; ci1 = 0; sub1 = 0; or1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  ir4, 1);
        chk("rst_out_valid", ov4, 0);
        chk("rst_busy",      busy4, 0);
        chk("rst_sum",       s4, 0);
        chk("rst_co_ovf",    {co4, ovf4}, 0);
        chk("rst_add",       {aa4, ab4, aci4}, 0);
        chk("rst1_ready",    ir1, 1);
        chk("rst1_sum",      s1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry through all bytes
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, s, co, ovf, lat, b0, c0);
        chk("t1_sum", s, 32'h0000_0000);
        chk("t1_co",  co, 1);
        chk("t1_ovf", ovf, 0);
        chk("t1_lat", lat, 5);

        // Subtract with borrow
        run_op(0, 32'h0000_0005, 32'h0000_0007, 0, 1, 0, s, co, ovf, lat, b0, c0);
        chk("t2_sum",  s, 32'hFFFF_FFFE);
        chk("t2_co",   co, 0);
        chk("t2_ovf",  ovf, 0);
        chk("t2_b0",   b0, 8'hF8);
        chk("t2_ci0",  c0, 1);

        // Signed overflow corners
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, s, co, ovf, lat, b0, c0);
        chk("t3a_sum", s, 32'h8000_0000);
        chk("t3a_ovf", ovf, 1);
        chk("t3a_co",  co, 0);
        run_op(0, 32'h8000_0000, 32'h0000_0001, 0, 1, 0, s, co, ovf, lat, b0, c0);
        chk("t3b_sum", s, 32'h7FFF_FFFF);
        chk("t3b_ovf", ovf, 1);
        chk("t3b_co",  co, 1);

        // Backpressure in DONE
        run_op(0, 32'h1234_0000, 32'h0000_5678, 1, 0, 3, s, co, ovf, lat, b0, c0);
        chk("t4_sum", s, 32'h1234_5679);
        chk("t4_lat", lat, 5);

        // Reset during ISSUE beat 2
        a4 = 32'h1234_5678; b4 = 32'h1111_1111; ci4 = 0; sub4 = 0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_busy_before", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_sum",       s4, 0);
        chk("t5_flags",     {co4, ovf4, ov4, busy4}, 0);
        chk("t5_add",       {aa4, ab4, aci4}, 0);
        chk("t5_in_ready",  ir4, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 32'h0000_0001, 32'h0000_0002, 0, 0, 0, s, co, ovf, lat, b0, c0);
        chk("t5_after_sum", s, 32'h0000_0003);
        chk("t5_after_lat", lat, 5);

        // Single-byte instance
        run_op(1, 32'h0000_00FF, 32'h0000_00FF, 1, 0, 0, s, co, ovf, lat, b0, c0);
        chk("t6_sum", s, 32'h0000_00FF);
        chk("t6_co",  co, 1);
        chk("t6_ovf", ovf, 0);
        chk("t6_lat", lat, 2);

        // Random operations against the reference
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
            run_op(0, ra, rb, rci, rsub, $urandom_range(0, 2), s, co, ovf, lat, b0, c0);
            ref_op(4, ra, rb, rci, rsub, es, eco, eovf);
            chk("rnd4_sum", s, es);
            chk("rnd4_co",  co, eco);
            chk("rnd4_ovf", ovf, eovf);
            chk("rnd4_lat", lat, 5);
        end
        for (int i = 0; i < 300; i++) begin
            ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
            run_op(1, ra, rb, rci, rsub, $urandom_range(0, 1), s, co, ovf, lat, b0, c0);
            ref_op(1, ra, rb, rci, rsub, es, eco, eovf);
            chk("rnd1_sum", s, es);
            chk("rnd1_co",  co, eco);
            chk("rnd1_ovf", ovf, eovf);
            chk("rnd1_lat", lat, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
